serial_word_collector: RTL
==========================

Name: serial_word_collector

Overview:
Receive-side counterpart to the 16-bit parallel-load shift register, which serialises a word out through its MSB/LSB taps. This block accepts the resulting serial bit stream, one bit per qualified cycle, and reassembles a WIDTH-bit parallel word. It supports MSB-first and LSB-first ordering. A completed word is presented through a valid/ready handshake to the downstream datapath or controller.

Parameters:
WIDTH, 16, word length in bits.
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin collecting a new word; discards any partial word.
msb_first  input  1  ordering, latched on start. 1 = first bit received is the word MSB; 0 = first bit is the LSB.
ser_valid  input  1  ser_in carries a valid bit this cycle.
ser_in  input  1  serial data bit.
par_out  output  WIDTH  assembled word; changes only on word completion.
word_valid  output  1  par_out holds a completed, unconsumed word.
word_ready  input  1  consumer accepts par_out this cycle.
busy  output  1  high while in COLLECT.
overrun  output  1  sticky; a bit arrived while a completed word was pending.

Behaviour:
- Reset, when rst=1 at a clock edge:
  - state=IDLE; internal shift register=0; counter=0.
  - par_out=0, word_valid=0, busy=0, overrun=0.
  - rst overrides every other input, including mid-COLLECT and HOLD.
- States: IDLE, COLLECT, HOLD. busy=(state==COLLECT); word_valid=(state==HOLD).
- IDLE:
  - ser_valid is ignored.
  - start=1: go to COLLECT, clear shift register and counter, latch msb_first, clear overrun.
- COLLECT, on each cycle with ser_valid=1:
  - msb_first latched 1: sr <= {sr[WIDTH-2:0], ser_in} (shift left, new bit enters LSB).
  - msb_first latched 0: sr <= {ser_in, sr[WIDTH-1:1]} (shift right, new bit enters MSB).
  - counter increments by 1.
- COLLECT, gaps: cycles with ser_valid=0 hold all state; gaps of any length are legal.
- Word completion, when ser_valid=1 and counter==WIDTH-1:
  - On that edge, par_out <= final shifted value (including the current bit), counter <= 0, state <= HOLD.
  - word_valid is high in the cycle after the last bit is sampled (latency 1 cycle from the final bit).
- start in COLLECT: restart. Partial word is discarded, counter=0, msb_first relatched. A ser_valid bit in the same cycle is dropped.
- HOLD:
  - par_out and word_valid are held stable until word_ready=1.
  - ser_valid=1 sets overrun (sticky) and the bit is dropped.
  - word_ready=1, start=0: go to IDLE.
  - word_ready=1, start=1: go directly to COLLECT (back-to-back word, no idle cycle); counter and shift register cleared, overrun cleared.
  - start=1 without word_ready: ignored.
- overrun clears only on rst or on an accepted start.
- par_out retains the last completed word through IDLE and COLLECT; it is never zeroed except by rst.
- Width rules: the counter wraps only through explicit clear. Counter values at or above WIDTH are unreachable.

Decomposition:
- Shared package / header:
  - WORD_W=16.
  - State encodings IDLE=2'b00, COLLECT=2'b01, HOLD=2'b10.
  - Ordering constants ORDER_MSB=1'b1, ORDER_LSB=1'b0.
  - The same package is used by the transmit-side controller.
- One sub-module: bit_counter (CNT_W-bit counter with sync clear, enable and terminal-count flag tc = (count==WIDTH-1)).
- FSM and shift datapath remain in serial_word_collector.

Test Plan:
- MSB-first basic: start with msb_first=1, then 16 consecutive valid bits of 0xA5C3, MSB first -> word_valid=1 one cycle after the 16th bit; par_out=0xA5C3; busy=0 from that cycle.
- LSB-first with gaps: msb_first=0; send 0x1234 LSB first with ser_valid low on every third cycle -> par_out=0x1234; counter frozen during gaps; no early word_valid.
- Handshake / back-to-back: hold word_ready=0 for 5 cycles -> par_out and word_valid stable. Then word_ready=1 and start=1 in the same cycle, followed by 0xFFFF MSB-first -> second word 0xFFFF with no IDLE cycle between words.
- Overrun: in HOLD with par_out=0x00FF, drive ser_valid=1 for 2 cycles -> overrun=1, par_out still 0x00FF. Next accepted start -> overrun=0.
- Restart mid-word: after 7 bits, pulse start with msb_first=1, then send 0x8001 -> par_out=0x8001 (partial bits discarded).
- Reset mid-operation: assert rst after 10 bits, and again in HOLD -> next cycle all outputs 0 and state IDLE; ser_valid in the following IDLE cycles causes no change.

Source files
------------

// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for the serial word link (collector and transmit-side controller).
// Provides the default word length, the FSM state encodings and the bit-ordering constants.
package serial_word_collector_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'b00;
    localparam state_t COLLECT = 2'b01;
    localparam state_t HOLD    = 2'b10;

    localparam logic ORDER_MSB = 1'b1;
    localparam logic ORDER_LSB = 1'b0;

endpackage

// File: rtl/serial_word_collector_if.sv
// Serial-in / parallel-out link bundle for serial_word_collector.
//   start, msb_first      : begin a new word and choose its bit ordering
//   ser_valid, ser_in     : qualified serial bit stream
//   par_out, word_valid   : completed word offered downstream
//   word_ready            : downstream accepts par_out
//   busy, overrun         : status (collecting / bit arrived while a word was pending)
// master = the side that drives the stream and consumes words; slave = the collector.
interface serial_word_collector_if
    import serial_word_collector_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
);
    logic             start;
    logic             msb_first;
    logic             ser_valid;
    logic             ser_in;
    logic [WIDTH-1:0] par_out;
    logic             word_valid;
    logic             word_ready;
    logic             busy;
    logic             overrun;

    modport master (
        output start, msb_first, ser_valid, ser_in, word_ready,
        input  par_out, word_valid, busy, overrun
    );

    modport slave (
        input  start, msb_first, ser_valid, ser_in, word_ready,
        output par_out, word_valid, busy, overrun
    );
endinterface

// File: rtl/serial_word_collector_bit_counter.sv
// CNT_W-bit received-bit counter with synchronous clear and count enable.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force count to 0 (wins over en)
//   en       : increment count
//   count    : current count
//   tc       : terminal count, high when count == WIDTH-1
module serial_word_collector_bit_counter
    import serial_word_collector_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/serial_word_collector.sv
// Reassembles a WIDTH-bit word from a qualified serial bit stream, MSB-first or LSB-first,
// and offers the completed word through a valid/ready handshake.
//   clk, rst : clock and synchronous active-high reset
//   bus      : serial_word_collector_if slave modport (stream in, word out, status)
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_word_collector_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             msb_q, msb_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] sr_shift;
    logic             begin_word;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt;

    serial_word_collector_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .tc    (cnt_tc)
    );

    // Shift register with the current bit already inserted; also the completed word on tc.
    always_comb begin
        if (msb_q == ORDER_MSB) begin
            sr_shift = {sr_q[WIDTH-2:0], bus.ser_in};
        end else begin
            sr_shift = {bus.ser_in, sr_q[WIDTH-1:1]};
        end
    end

    // A start is honoured in IDLE and COLLECT, but in HOLD only together with word_ready.
    always_comb begin
        begin_word = 1'b0;
        if (bus.start) begin
            begin_word = (state_q == IDLE) || (state_q == COLLECT) ||
                         ((state_q == HOLD) && bus.word_ready);
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        par_d   = par_q;
        msb_d   = msb_q;
        ovr_d   = ovr_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            COLLECT: begin
                // A restart drops any bit presented in the same cycle.
                if (!bus.start && bus.ser_valid) begin
                    sr_d   = sr_shift;
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        par_d   = sr_shift;
                        cnt_clr = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Bits arriving while a word is pending are dropped and flagged.
                if (bus.ser_valid) begin
                    ovr_d = 1'b1;
                end
                if (bus.word_ready) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (begin_word) begin
            state_d = COLLECT;
            sr_d    = '0;
            msb_d   = bus.msb_first;
            ovr_d   = 1'b0;
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            par_q   <= '0;
            msb_q   <= ORDER_MSB;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            msb_q   <= msb_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.par_out    = par_q;
    assign bus.word_valid = (state_q == HOLD);
    assign bus.busy       = (state_q == COLLECT);
    assign bus.overrun    = ovr_q;

    // The counter is cleared on completion, so it never reaches WIDTH.
    count_in_range_a: assert property (@(posedge clk) disable iff (rst) cnt < CNT_W'(WIDTH));
endmodule
